mul_serial_mac: RTL and testbench

Parametrised bit-serial signed multiply-accumulate unit for the binary-serial PE datapath. It accepts one two's-complement operand pair per valid/ready handshake and consumes the multiplier `BPC` bits per cycle, LSB first. Each cycle it adds the shifted partial product into an internal accumulator. It presents the finished sum on a valid/ready output port, and the unit can either start a fresh sum or accumulate onto the previous result.

---
 rtl/mul_serial_mac.sv | 104 ++++++++++
 tb/tb_mul_serial_mac.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_serial_mac.sv
// Bit-serial signed multiply-accumulate, BPC multiplier bits per cycle.
// Finished sum is offered on a valid/ready port; accumulator chains across ops.
module mul_serial_mac #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1,
    parameter int GUARD = 4,
    localparam int ACC_W = 2 * WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_acc,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_data,
    output logic             o_busy
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0) begin : g_bad_cfg
        $error("mul_serial_mac: BPC must be 1, 2 or 4 and divide WIDTH");
    end

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        mplier;
    logic signed [WIDTH-1:0] mcand;
    logic [ACC_W-1:0]        acc;

    logic [BPC-1:0]            raw;
    logic signed [BPC:0]       digit;
    logic signed [WIDTH+BPC:0] pp;
    logic signed [ACC_W-1:0]   ppx;
    logic [ACC_W-1:0]          addend;

    // Current digit times multiplicand, weighted by its bit position;
    // only the top digit carries the two's-complement sign weight.
    always_comb begin
        raw    = mplier[int'(cnt) * BPC +: BPC];
        digit  = (cnt == LAST) ? {raw[BPC-1], raw} : {1'b0, raw};
        pp     = digit * mcand;
        ppx    = ACC_W'(pp);
        addend = ppx << (int'(cnt) * BPC);
    end

    // Handshake FSM, digit counter and accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mplier <= '0;
            mcand  <= '0;
        end else if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (i_valid) begin
                        mplier <= i_data0;
                        mcand  <= i_data1;
                        cnt    <= '0;
                        state  <= S_BUSY;
                        if (!i_acc) begin
                            acc <= '0;
                        end
                    end
                end
                (state == S_BUSY): begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                (state == S_DONE): begin
                    if (o_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign i_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);
    assign o_busy  = (state == S_BUSY);
    assign o_data  = acc;

endmodule

// File: tb/tb_mul_serial_mac.sv
// Bench for mul_serial_mac: BPC=1 and BPC=4 instances side by side,
// scoreboard of expected sums checked when each result appears.
module tb_mul_serial_mac;

    logic        clk;
    logic        rst_n;
    logic        clr    [2];
    logic        v      [2];
    logic        rdy    [2];
    logic        acc_in [2];
    logic [15:0] d0     [2];
    logic [15:0] d1     [2];
    logic        ov     [2];
    logic        ordy   [2];
    logic [35:0] od     [2];
    logic        busy   [2];

    logic [35:0] model [2];
    logic [35:0] sb_q  [$];
    int n_chk;
    int n_pass;

    mul_serial_mac #(.WIDTH(16), .BPC(1), .GUARD(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .i_valid(v[0]), .i_ready(rdy[0]), .i_acc(acc_in[0]),
        .i_data0(d0[0]), .i_data1(d1[0]),
        .o_valid(ov[0]), .o_ready(ordy[0]), .o_data(od[0]),
        .o_busy(busy[0])
    );

    mul_serial_mac #(.WIDTH(16), .BPC(4), .GUARD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .i_valid(v[1]), .i_ready(rdy[1]), .i_acc(acc_in[1]),
        .i_data0(d0[1]), .i_data1(d1[1]),
        .o_valid(ov[1]), .o_ready(ordy[1]), .o_data(od[1]),
        .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int s);
        int n = 0;
        while (!rdy[s] && n < 50) begin
            tick();
            n++;
        end
        if (!rdy[s]) chk("rdy_timeout", 0, 1);
    endtask

    task automatic start(input int s, input int a, input int b, input bit acc);
        wait_rdy(s);
        v[s]      = 1'b1;
        d0[s]     = 16'(a);
        d1[s]     = 16'(b);
        acc_in[s] = acc;
        tick();
        v[s]      = 1'b0;
        acc_in[s] = 1'b0;
    endtask

    task automatic do_op(input int s, input int a, input int b,
                         input bit acc, input int hold);
        longint p;
        logic [35:0] exp;
        int lat;
        p = longint'(a) * longint'(b);
        model[s] = (acc ? model[s] : 36'd0) + 36'(p);
        sb_q.push_back(model[s]);
        start(s, a, b, acc);
        chk("busy_after_accept", busy[s], 1);
        lat = 0;
        while (!ov[s] && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", lat, (s == 1) ? 4 : 16);
        exp = sb_q.pop_front();
        chk("o_data", od[s], exp);
        chk("i_ready_in_done", rdy[s], 0);
        for (int i = 0; i < hold; i++) begin
            v[s]  = i[0];
            d0[s] = 16'($urandom_range(0, 65535));
            tick();
            chk("hold_data", od[s], exp);
            chk("hold_valid", ov[s], 1);
            chk("hold_irdy", rdy[s], 0);
        end
        v[s]    = 1'b0;
        ordy[s] = 1'b1;
        tick();
        ordy[s] = 1'b0;
        chk("idle_irdy", rdy[s], 1);
        chk("idle_ovalid", ov[s], 0);
    endtask

    task automatic chk_reset_vals(input int s);
        chk("rst_irdy", rdy[s], 1);
        chk("rst_ovalid", ov[s], 0);
        chk("rst_busy", busy[s], 0);
        chk("rst_odata", od[s], 0);
    endtask

    initial begin
        int n;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            clr[s] = 0; v[s] = 0; acc_in[s] = 0;
            d0[s] = '0; d1[s] = '0; ordy[s] = 0; model[s] = '0;
        end
        #23;
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n = 1'b1;
        tick();

        do_op(0, 3, -5, 0, 0);
        chk("m3x-5_const", od[0], 36'hFFFFFFFF1);
        do_op(0, -32768, -32768, 0, 0);
        do_op(1, -32768, -32768, 0, 0);
        chk("minxmin_const", od[1], 36'h040000000);
        do_op(0, 32767, -32768, 0, 0);
        do_op(1, 32767, -32768, 0, 0);

        do_op(1, 100, 200, 0, 0);
        do_op(1, -50, 10, 1, 0);
        chk("chain_19500", od[1], 36'd19500);
        do_op(1, 7, 7, 0, 0);
        do_op(0, 100, 200, 0, 0);
        do_op(0, -50, 10, 1, 0);

        do_op(0, 123, -456, 0, 5);
        do_op(1, -789, 321, 1, 5);

        for (int i = 0; i < 6; i++) begin
            do_op(i % 2, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  bit'($urandom_range(0, 1)), 0);
        end

        start(0, 9, 9, 0);
        for (int i = 0; i < 7; i++) tick();
        chk("clr_busy_before", busy[0], 1);
        clr[0] = 1'b1;
        v[0]   = 1'b1;
        tick();
        clr[0] = 1'b0;
        v[0]   = 1'b0;
        model[0] = '0;
        chk("clr_irdy", rdy[0], 1);
        chk("clr_odata", od[0], 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov[0]) n++;
            tick();
        end
        chk("clr_no_ovalid", n, 0);
        do_op(0, 4, 4, 1, 0);
        chk("clr_then_16", od[0], 36'd16);

        start(1, 3, -5, 0);
        tick();
        chk("mid_busy", busy[1], 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(1);
        chk_reset_vals(0);
        #1 rst_n = 1'b1;
        model[0] = '0;
        model[1] = '0;
        tick();

        start(0, 5, 6, 0);
        n = 0;
        while (!ov[0] && n < 50) begin
            tick();
            n++;
        end
        chk("done_before_rst", ov[0], 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(0);
        #1 rst_n = 1'b1;
        tick();
        do_op(0, -3, 7, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
